// File: rtl/i3c_fmt_fifo_if.sv
// rtl/i3c_fmt_fifo_if.sv - write, pop and status signals of the i3c format-command FIFO
// Low-water ports exist only when I3C_FMT_FIFO_LOWWATER_EN is defined.
interface i3c_fmt_fifo_if #(
    parameter int FifoDepth = 64
);
    localparam int FifoDepthWidth = $clog2(FifoDepth + 1);
    localparam int EntryWidth     = 13;

    logic                      wvalid_i;
    logic                      wready_o;
    logic [EntryWidth-1:0]     wdata_i;
    logic                      clr_i;
    logic                      fmt_fifo_rvalid_o;
    logic                      fmt_fifo_rready_i;
    logic [FifoDepthWidth-1:0] fmt_fifo_depth_o;
    logic [7:0]                fmt_byte_o;
    logic                      fmt_flag_start_before_o;
    logic                      fmt_flag_stop_after_o;
    logic                      fmt_flag_read_bytes_o;
    logic                      fmt_flag_read_continue_o;
    logic                      fmt_flag_nak_ok_o;
    logic                      full_o;
    logic                      empty_o;
    logic                      overflow_o;
`ifdef I3C_FMT_FIFO_LOWWATER_EN
    logic [FifoDepthWidth-1:0] lowwater_thresh_i;
    logic                      lowwater_o;
`endif

    modport master (
        output wvalid_i, wdata_i, clr_i, fmt_fifo_rready_i,
`ifdef I3C_FMT_FIFO_LOWWATER_EN
        output lowwater_thresh_i,
        input  lowwater_o,
`endif
        input  wready_o, fmt_fifo_rvalid_o, fmt_fifo_depth_o, fmt_byte_o,
        input  fmt_flag_start_before_o, fmt_flag_stop_after_o, fmt_flag_read_bytes_o,
        input  fmt_flag_read_continue_o, fmt_flag_nak_ok_o,
        input  full_o, empty_o, overflow_o
    );

    modport slave (
        input  wvalid_i, wdata_i, clr_i, fmt_fifo_rready_i,
`ifdef I3C_FMT_FIFO_LOWWATER_EN
        input  lowwater_thresh_i,
        output lowwater_o,
`endif
        output wready_o, fmt_fifo_rvalid_o, fmt_fifo_depth_o, fmt_byte_o,
        output fmt_flag_start_before_o, fmt_flag_stop_after_o, fmt_flag_read_bytes_o,
        output fmt_flag_read_continue_o, fmt_flag_nak_ok_o,
        output full_o, empty_o, overflow_o
    );
endinterface

// File: rtl/i3c_fmt_fifo.sv
// rtl/i3c_fmt_fifo.sv - show-ahead format-command FIFO feeding the i3c controller
// Optional low-water flag built when I3C_FMT_FIFO_LOWWATER_EN is defined.
module i3c_fmt_fifo #(
    parameter int FifoDepth = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    i3c_fmt_fifo_if.slave   bus
);
    localparam int FifoDepthWidth = $clog2(FifoDepth + 1);
    localparam int EntryWidth     = 13;
    localparam int AddrW          = $clog2(FifoDepth);
    localparam int PtrW           = AddrW + 1;

    logic [PtrW-1:0]           wptr_q, wptr_d;
    logic [PtrW-1:0]           rptr_q, rptr_d;
    logic [FifoDepthWidth-1:0] depth_q, depth_d;
    logic                      overflow_q, overflow_d;
    logic [EntryWidth-1:0]     mem_q [FifoDepth];
    logic [EntryWidth-1:0]     mem_d [FifoDepth];
    logic                      full, empty, push, pop;
    logic [EntryWidth-1:0]     head;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign full  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign push  = bus.wvalid_i && !full && !bus.clr_i;
    assign pop   = bus.fmt_fifo_rready_i && !empty && !bus.clr_i;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        depth_d    = depth_q;
        overflow_d = 1'b0;
        mem_d      = mem_q;
        if (bus.clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            depth_d = '0;
        end else begin
            overflow_d = bus.wvalid_i && full;
            if (push) begin
                mem_d[wptr_q[AddrW-1:0]] = bus.wdata_i;
                wptr_d = wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                depth_d = depth_q + FifoDepthWidth'(1);
            end else if (pop && !push) begin
                depth_d = depth_q - FifoDepthWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            depth_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            depth_q    <= depth_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Storage is never reset, so the head is zeroed while empty to keep outputs defined.
    assign head = empty ? '0 : mem_q[rptr_q[AddrW-1:0]];

    assign bus.wready_o                 = !full;
    assign bus.fmt_fifo_rvalid_o        = !empty;
    assign bus.full_o                   = full;
    assign bus.empty_o                  = empty;
    assign bus.overflow_o               = overflow_q;
    assign bus.fmt_fifo_depth_o         = depth_q;
    assign bus.fmt_byte_o               = head[7:0];
    assign bus.fmt_flag_start_before_o  = head[8];
    assign bus.fmt_flag_stop_after_o    = head[9];
    assign bus.fmt_flag_read_bytes_o    = head[10];
    assign bus.fmt_flag_read_continue_o = head[11];
    assign bus.fmt_flag_nak_ok_o        = head[12];

`ifdef I3C_FMT_FIFO_LOWWATER_EN
    logic lowwater_q, lowwater_d;

    // Threshold 0 can never be undercut, so the flag stays low after the first update.
    always_comb begin
        lowwater_d = (depth_d < bus.lowwater_thresh_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lowwater_q <= 1'b1;
        end else begin
            lowwater_q <= lowwater_d;
        end
    end

    assign bus.lowwater_o = lowwater_q;
`endif
endmodule
